// File: rtl/hockey_display.sv
// hockey_display: scanned 8-digit seven-segment and LED back-end for air hockey.
// Define HOCKEY_DISP_BLINK_EN to blink goal/win indications on the display and LEDs.
module hockey_display #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] x_coord,
    input  logic [2:0] y_coord,
    input  logic [1:0] score_a,
    input  logic [1:0] score_b,
    input  logic [2:0] mode,
    output logic [4:0] LEDX,
    output logic       LEDA,
    output logic       LEDB,
    output logic [6:0] seg,
    output logic [7:0] an
);

    typedef enum logic [2:0] {
        M_IDLE   = 3'd0,
        M_TURN_A = 3'd1,
        M_TURN_B = 3'd2,
        M_PLAY   = 3'd3,
        M_GOAL_A = 3'd4,
        M_GOAL_B = 3'd5,
        M_WIN_A  = 3'd6,
        M_WIN_B  = 3'd7
    } mode_t;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_A     = 7'h08;
    localparam logic [6:0] G_B     = 7'h03;

    if (SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("hockey_display: SCAN_DIV and BLINK_DIV must be >= 1");
    end

    function automatic logic [6:0] num_glyph(input logic [2:0] v);
        logic [6:0] g;
        unique case (v)
            3'd0: g = 7'h40;
            3'd1: g = 7'h79;
            3'd2: g = 7'h24;
            3'd3: g = 7'h30;
            3'd4: g = 7'h19;
            3'd5: g = 7'h12;
            3'd6: g = 7'h02;
            3'd7: g = 7'h78;
        endcase
        return g;
    endfunction

    mode_t mode_in;
    assign mode_in = mode_t'(mode);

    logic            started_q, started_d;
    logic [2:0]      idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            wrap, snap;

    mode_t           sh_mode_q, sh_mode_d;
    logic [1:0]      sh_sa_q, sh_sa_d;
    logic [1:0]      sh_sb_q, sh_sb_d;
    logic [2:0]      sh_x_q, sh_x_d;
    logic [2:0]      sh_y_q, sh_y_d;

    logic [6:0]      seg_q, seg_d;
    logic [7:0]      an_q, an_d;
    logic [4:0]      ledx_q, ledx_d;
    logic            leda_q, leda_d;
    logic            ledb_q, ledb_d;

    logic            blink_seg;
    logic            blink_led;

    // Scan position; the first edge after reset only arms the scan on digit 7.
    always_comb begin
        started_d = 1'b1;
        idx_d     = idx_q;
        dwell_d   = dwell_q;
        wrap      = 1'b0;
        if (started_q) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                idx_d   = idx_q - 3'd1;
                wrap    = (idx_q == 3'd0);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
        snap = wrap || !started_q;
    end

    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_sa_d   = sh_sa_q;
        sh_sb_d   = sh_sb_q;
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        if (snap) begin
            sh_mode_d = mode_in;
            sh_sa_d   = score_a;
            sh_sb_d   = score_b;
            sh_x_d    = x_coord;
            sh_y_d    = y_coord;
        end
    end

`ifdef HOCKEY_DISP_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (sh_mode_d != sh_mode_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_seg = phase_d;
    assign blink_led = phase_q;
`else
    assign blink_seg = 1'b0;
    assign blink_led = 1'b0;
`endif

    // Content for the digit being enabled next, taken from the (new) snapshot.
    always_comb begin
        seg_d = G_BLANK;
        unique case (sh_mode_d)
            M_IDLE: seg_d = G_DASH;
            M_TURN_A: if (idx_d == 3'd7) seg_d = G_A;
            M_TURN_B: if (idx_d == 3'd0) seg_d = G_B;
            M_PLAY: begin
                case (idx_d)
                    3'd7:    seg_d = num_glyph({1'b0, sh_sa_d});
                    3'd6:    seg_d = G_DASH;
                    3'd5:    seg_d = num_glyph({1'b0, sh_sb_d});
                    3'd1:    seg_d = num_glyph(sh_x_d);
                    3'd0:    seg_d = num_glyph(sh_y_d);
                    default: seg_d = G_BLANK;
                endcase
            end
            M_GOAL_A, M_GOAL_B: begin
                case (idx_d)
                    3'd7:    seg_d = num_glyph({1'b0, sh_sa_d});
                    3'd6:    seg_d = G_DASH;
                    3'd5:    seg_d = num_glyph({1'b0, sh_sb_d});
                    default: seg_d = G_BLANK;
                endcase
                if (blink_seg && sh_mode_d == M_GOAL_A && idx_d == 3'd7)
                    seg_d = G_BLANK;
                if (blink_seg && sh_mode_d == M_GOAL_B && idx_d == 3'd5)
                    seg_d = G_BLANK;
            end
            M_WIN_A: begin
                case (idx_d)
                    3'd7:    seg_d = blink_seg ? G_BLANK : G_A;
                    3'd6:    seg_d = num_glyph({1'b0, sh_sa_d});
                    3'd5:    seg_d = num_glyph({1'b0, sh_sb_d});
                    default: seg_d = G_BLANK;
                endcase
            end
            M_WIN_B: begin
                case (idx_d)
                    3'd7:    seg_d = num_glyph({1'b0, sh_sa_d});
                    3'd6:    seg_d = num_glyph({1'b0, sh_sb_d});
                    3'd0:    seg_d = blink_seg ? G_BLANK : G_B;
                    default: seg_d = G_BLANK;
                endcase
            end
        endcase
        an_d = ~(8'd1 << idx_d);
    end

    always_comb begin
        ledx_d = '0;
        if (mode_in == M_PLAY && y_coord < 3'd5)
            ledx_d = 5'd1 << y_coord;
        leda_d = (mode_in == M_TURN_A) ||
                 ((mode_in == M_GOAL_A || mode_in == M_WIN_A) && !blink_led);
        ledb_d = (mode_in == M_TURN_B) ||
                 ((mode_in == M_GOAL_B || mode_in == M_WIN_B) && !blink_led);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q <= 1'b0;
            idx_q     <= 3'd7;
            dwell_q   <= '0;
            sh_mode_q <= M_IDLE;
            sh_sa_q   <= '0;
            sh_sb_q   <= '0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            seg_q     <= G_BLANK;
            an_q      <= 8'hFF;
            ledx_q    <= '0;
            leda_q    <= 1'b0;
            ledb_q    <= 1'b0;
        end else begin
            started_q <= started_d;
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            sh_mode_q <= sh_mode_d;
            sh_sa_q   <= sh_sa_d;
            sh_sb_q   <= sh_sb_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            ledx_q    <= ledx_d;
            leda_q    <= leda_d;
            ledb_q    <= ledb_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign LEDX = ledx_q;
    assign LEDA = leda_q;
    assign LEDB = ledb_q;

endmodule

// File: tb/tb_hockey_display.sv
// tb_hockey_display: directed checks of scan order, snapshot timing,
// digit content, LED path, blink behaviour and mid-frame reset.
module tb_hockey_display;

    localparam int SD = 4;
    localparam int FR = 8 * SD;
`ifdef HOCKEY_DISP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] x_coord = '0;
    logic [2:0] y_coord = '0;
    logic [1:0] score_a = '0;
    logic [1:0] score_b = '0;
    logic [2:0] mode = '0;
    logic [4:0] LEDX;
    logic       LEDA;
    logic       LEDB;
    logic [6:0] seg;
    logic [7:0] an;

    hockey_display #(.SCAN_DIV(SD), .BLINK_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_coord (x_coord),
        .y_coord (y_coord),
        .score_a (score_a),
        .score_b (score_b),
        .mode    (mode),
        .LEDX    (LEDX),
        .LEDA    (LEDA),
        .LEDB    (LEDB),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int pos     = 0;
    logic [6:0] exp_d [8];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set8(input logic [6:0] d7, input logic [6:0] d6,
                        input logic [6:0] d5, input logic [6:0] d4,
                        input logic [6:0] d3, input logic [6:0] d2,
                        input logic [6:0] d1, input logic [6:0] d0);
        exp_d[7] = d7; exp_d[6] = d6; exp_d[5] = d5; exp_d[4] = d4;
        exp_d[3] = d3; exp_d[2] = d2; exp_d[1] = d1; exp_d[0] = d0;
    endtask

    // Step n clocks, checking the enabled digit and its glyph each cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int dig;
            @(posedge clk);
            @(negedge clk);
            dig = 7 - pos / SD;
            chk($sformatf("an p%0d", pos), an, ~(8'd1 << dig));
            chk($sformatf("seg d%0d", dig), {1'b0, seg}, {1'b0, exp_d[dig]});
            pos = (pos + 1) % FR;
        end
    endtask

    task automatic chk_leds(input logic [4:0] ex, input logic ea,
                            input logic eb);
        chk("LEDX", {3'b0, LEDX}, {3'b0, ex});
        chk("LEDA", {7'b0, LEDA}, {7'b0, ea});
        chk("LEDB", {7'b0, LEDB}, {7'b0, eb});
    endtask

    initial begin
        bit blk;

        @(negedge clk);
        chk("rst seg", {1'b0, seg}, 8'h7F);
        chk("rst an", an, 8'hFF);
        chk_leds(5'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        pos = 0;
        set8(DS, DS, DS, DS, DS, DS, DS, DS);
        run(FR);

        mode = 3'd3; score_a = 2'd2; score_b = 2'd1;
        x_coord = 3'd4; y_coord = 3'd2;
        set8(7'h24, DS, 7'h79, BL, BL, BL, 7'h19, 7'h24);
        run(1);
        chk_leds(5'b00100, 1'b0, 1'b0);
        run(FR - 1);

        y_coord = 3'd1;
        exp_d[0] = 7'h79;
        run(1);
        chk_leds(5'b00010, 1'b0, 1'b0);
        run(15);
        y_coord = 3'd3;
        run(1);
        chk_leds(5'b01000, 1'b0, 1'b0);
        run(FR - 17);
        exp_d[0] = 7'h30;
        run(FR);

        mode = 3'd1;
        set8(7'h08, BL, BL, BL, BL, BL, BL, BL);
        run(1);
        chk_leds(5'b0, 1'b1, 1'b0);
        run(FR - 1);

        mode = 3'd7; score_a = 2'd1; score_b = 2'd3;
        set8(7'h79, 7'h30, BL, BL, BL, BL, BL, 7'h03);
        run(1);
        chk_leds(5'b0, 1'b0, 1'b1);
        run(FR - 1);

        mode = 3'd4; score_a = 2'd3; score_b = 2'd0;
        for (int k = 0; k < 5; k++) begin
            blk = BLINK && (k == 2 || k == 3);
            set8(blk ? BL : 7'h30, DS, 7'h40, BL, BL, BL, BL, BL);
            run(FR / 2);
            chk_leds(5'b0, !blk, 1'b0);
            run(FR / 2);
        end

        run(17);
        rst = 1'b0;
        #1;
        chk("midrst seg", {1'b0, seg}, 8'h7F);
        chk("midrst an", an, 8'hFF);
        chk_leds(5'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold an", an, 8'hFF);
        rst = 1'b1;
        pos = 0;
        set8(7'h30, DS, 7'h40, BL, BL, BL, BL, BL);
        run(FR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
